conv3x3_mac: RTL and testbench
==============================

Name: conv3x3_mac

Overview:
- Downstream stage of the 3x3 window shift register in the conv datapath.
- Consumes one 3x3 signed pixel window plus the 9 matching signed weights per accepted beat.
- Computes the pipelined dot product, scales it, then saturates (optionally ReLU) to an 8-bit output pixel.
- Tags each output with its position in the 17x17 valid-convolution output of a 19x19 input, and pulses finish when the feature map is complete.

Parameters:
- DW, 8, pixel and weight width (signed)
- ACCW, 20, accumulator width (signed)
- SHIFT, 4, arithmetic right shift applied to the sum before saturation
- OUT_W, 17, output columns per map
- OUT_H, 17, output rows per map

Ports:
- clk  in  1  clock, rising edge
- xrst  in  1  reset, asynchronous, active-high
- start  in  1  begin one feature map; single-cycle pulse
- in_valid  in  1  window/weights valid this cycle
- win  in  9*DW  pixels p0..p8, p0 in LSBs, row-major (p0 top-left)
- wgt  in  9*DW  weights w0..w8, same order as win
- out_valid  out  1  out_data valid
- out_data  out  DW  saturated result pixel
- out_x  out  5  output column, 0..OUT_W-1
- out_y  out  5  output row, 0..OUT_H-1
- busy  out  1  high in RUN and DRAIN
- finish  out  1  single-cycle completion pulse

Behaviour:
- Reset (async, xrst=1): state IDLE; all pipeline valids, counters, out_valid, out_data, out_x, out_y, busy and finish go to 0.
- FSM states and transitions:
  - IDLE: on start go to RUN; clear the input count and the out_x/out_y counters.
  - RUN: each in_valid=1 beat is accepted and in_cnt increments. The beat that makes in_cnt reach OUT_W*OUT_H (289) moves the FSM to DRAIN.
  - DRAIN: no inputs accepted. Go to DONE when the final out_valid has been emitted.
  - DONE: finish=1 for exactly one cycle, then IDLE.
- start is ignored outside IDLE. in_valid is ignored in IDLE, DRAIN and DONE.
- Pipeline (3 stages, latency 3 cycles from accepted beat to out_valid, one beat per cycle, no backpressure):
  - S1: nine signed DWxDW products, registered at 2*DW bits.
  - S2: signed adder tree, sign-extended to ACCW, registered.
  - S3: arithmetic shift right by SHIFT (floor toward -inf), then clamp to [-128,127], registered to out_data.
- Bubbles in in_valid propagate as bubbles. Output order equals input order.
- Position counters: out_x increments on every out_valid. At OUT_W-1 it wraps to 0 and out_y increments. out_x/out_y reflect the current output while out_valid=1 and advance after it.
- Worst case |sum| = 9*2^14 = 147456 fits ACCW=20 without overflow.
- Timing of the last output: the 289th out_valid is followed by DONE in the next cycle, so finish comes 1 cycle after the last out_valid.
- Start on the same cycle as finish: ignored (FSM not in IDLE).
- Reset asserted mid-map: the map is abandoned with no finish. A new start is required.

Optional Feature:
- Macro CONV_RELU_EN.
- Defined: the S3 clamp lower bound becomes 0 (negative results output 0).
- Undefined: signed saturation to [-128,127].

Decomposition:
- Package conv_pkg holds: DW, ACCW, OUT_W, OUT_H, the state enum (IDLE, RUN, DRAIN, DONE), and the SAT_MAX/SAT_MIN constants.
- Sub-module sat_shift: the combinational shift + clamp with the ReLU option, instantiated in S3.

Test Plan:
- All pixels 1, all weights 16, 289 back-to-back beats -> 289 out_valid, each out_data=9. First out_valid 3 cycles after the first beat. Last output at (16,16). finish 1 cycle after the last out_valid.
- Pixels 16, weights 16 (sum 2304) -> out_data=127 (saturated). Pixels -128, weights -128 -> 127.
- Pixels 1, weights -16 -> out_data=-9 (0xF7) without CONV_RELU_EN; 0 with it.
- in_valid toggled 1,0,1,0 with start held high mid-run -> outputs spaced identically, extra start ignored, position counters correct (x wraps 16->0 with y+1).
- xrst pulse after 100 beats -> all outputs 0 immediately (asynchronous), no finish. A new start + 289 beats -> normal completion.
- in_valid held high for 300 cycles -> exactly 289 accepted, extra beats dropped, single finish pulse.

Source files
------------

// File: rtl/conv_pkg.sv
// conv_pkg: shared widths, map geometry, saturation limits and FSM states for conv3x3_mac
package conv_pkg;
  localparam int DW = 8;
  localparam int ACCW = 20;
  localparam int OUT_W = 17;
  localparam int OUT_H = 17;
  localparam logic signed [DW-1:0] SAT_MAX = {1'b0, {DW-1{1'b1}}};
  localparam logic signed [DW-1:0] SAT_MIN = {1'b1, {DW-1{1'b0}}};
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
endpackage

// File: rtl/conv3x3_mac_sat_shift.sv
// sat_shift: arithmetic shift then clamp to the output pixel range; CONV_RELU_EN raises the lower bound to 0
module sat_shift
  import conv_pkg::*;
#(
  parameter int SHIFT = 4
) (
  input  logic signed [ACCW-1:0] sum,
  output logic [DW-1:0]          pix
);
  localparam logic signed [ACCW-1:0] HI = ACCW'(SAT_MAX);
`ifdef CONV_RELU_EN
  localparam logic signed [ACCW-1:0] LO = '0;
`else
  localparam logic signed [ACCW-1:0] LO = ACCW'(SAT_MIN);
`endif
  logic signed [ACCW-1:0] sh;
  assign sh = sum >>> SHIFT;
  assign pix = sh > HI ? HI[DW-1:0] : sh < LO ? LO[DW-1:0] : sh[DW-1:0];
endmodule

// File: rtl/conv3x3_mac.sv
// conv3x3_mac: 3-stage 3x3 MAC with shift/saturate and output position tagging; CONV_RELU_EN selects ReLU clamp
module conv3x3_mac
  import conv_pkg::*;
#(
  parameter int SHIFT = 4
) (
  input  logic            clk,
  input  logic            xrst,
  input  logic            start,
  input  logic            in_valid,
  input  logic [9*DW-1:0] win,
  input  logic [9*DW-1:0] wgt,
  output logic            out_valid,
  output logic [DW-1:0]   out_data,
  output logic [4:0]      out_x,
  output logic [4:0]      out_y,
  output logic            busy,
  output logic            finish
);
  localparam int TOTAL = OUT_W * OUT_H;
  localparam int CW = $clog2(TOTAL + 1);
  localparam int PW = 2 * DW;
  state_t state, state_n;
  logic accept, last_col, last_out, v1, v2;
  logic [CW-1:0] in_cnt;
  logic signed [PW-1:0] prod [9];
  logic signed [PW-1:0] prod_c [9];
  logic signed [ACCW-1:0] sum, sum_c;
  logic [DW-1:0] sat;
  assign last_col = out_x == 5'(OUT_W - 1);
  assign last_out = out_valid && last_col && out_y == 5'(OUT_H - 1);
  always_comb begin
    for (int i = 0; i < 9; i++)
      prod_c[i] = PW'($signed(win[i*DW +: DW])) * PW'($signed(wgt[i*DW +: DW]));
  end
  always_comb begin
    sum_c = '0;
    for (int i = 0; i < 9; i++)
      sum_c = sum_c + ACCW'(prod[i]);
  end
  always_comb begin
    state_n = state;
    accept = 1'b0;
    busy = 1'b0;
    finish = 1'b0;
    case (state)
      IDLE: state_n = start ? RUN : IDLE;
      RUN: begin
        busy = 1'b1;
        accept = in_valid;
        state_n = in_valid && in_cnt == CW'(TOTAL - 1) ? DRAIN : RUN;
      end
      DRAIN: begin
        busy = 1'b1;
        state_n = last_out ? DONE : DRAIN;
      end
      default: begin
        finish = 1'b1;
        state_n = IDLE;
      end
    endcase
  end
  always_ff @(posedge clk or posedge xrst)
    if (xrst) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk or posedge xrst)
    if (xrst) begin
      in_cnt <= '0;
      out_x <= '0;
      out_y <= '0;
    end else if (state == IDLE && start) begin
      in_cnt <= '0;
      out_x <= '0;
      out_y <= '0;
    end else begin
      if (accept) in_cnt <= in_cnt + 1'b1;
      if (out_valid) begin
        out_x <= last_col ? '0 : out_x + 1'b1;
        if (last_col) out_y <= out_y + 1'b1;
      end
    end
  // Data registers only load on a valid beat so bubbles stay bubbles
  always_ff @(posedge clk or posedge xrst)
    if (xrst) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      out_valid <= 1'b0;
      out_data <= '0;
      sum <= '0;
      for (int i = 0; i < 9; i++) prod[i] <= '0;
    end else begin
      v1 <= accept;
      v2 <= v1;
      out_valid <= v2;
      if (accept) prod <= prod_c;
      if (v1) sum <= sum_c;
      if (v2) out_data <= sat;
    end
  sat_shift #(.SHIFT(SHIFT)) u_sat (
    .sum(sum),
    .pix(sat)
  );
endmodule

// File: tb/tb_conv3x3_mac.sv
// tb_conv3x3_mac: table vectors and random maps checked against a plain-arithmetic dot-product model
module tb_conv3x3_mac;
  typedef struct {int p; int w; int e;} vec_t;
  typedef struct {int d; int idx; int cyc;} exp_t;
  logic clk = 0, xrst = 1, start = 0, in_valid = 0;
  logic [71:0] win = '0, wgt = '0;
  logic out_valid, busy, finish;
  logic [7:0] out_data;
  logic [4:0] out_x, out_y;
  int vectors = 0, errs = 0, cyc = 0, fin_cnt = 0, last_cyc = -100;
  exp_t q[$];
  exp_t ce;
  vec_t tab[9];
  conv3x3_mac dut (
    .clk(clk), .xrst(xrst), .start(start), .in_valid(in_valid), .win(win), .wgt(wgt),
    .out_valid(out_valid), .out_data(out_data), .out_x(out_x), .out_y(out_y),
    .busy(busy), .finish(finish)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  task automatic chk(input string nm, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  function automatic int clampv(input int v);
`ifdef CONV_RELU_EN
    return v > 127 ? 127 : v < 0 ? 0 : v;
`else
    return v > 127 ? 127 : v < -128 ? -128 : v;
`endif
  endfunction
  function automatic int model(input logic [71:0] pw, input logic [71:0] gw);
    int s = 0, qt;
    logic signed [7:0] a, b;
    for (int i = 0; i < 9; i++) begin
      a = pw[i*8 +: 8];
      b = gw[i*8 +: 8];
      s += int'(a) * int'(b);
    end
    qt = s / 16;
    if (s < 0 && s % 16 != 0) qt--;
    return clampv(qt);
  endfunction
  always @(negedge clk) if (!xrst) begin
    if (out_valid) begin
      if (q.size() == 0) begin
        vectors++;
        errs++;
        $display("FAIL spurious_out: got out_valid=1 expected 0");
      end else begin
        ce = q.pop_front();
        chk("out_data", int'($signed(out_data)), ce.d);
        chk("out_x", int'(out_x), ce.idx % 17);
        chk("out_y", int'(out_y), ce.idx / 17);
        chk("latency", cyc - ce.cyc, 3);
        if (ce.idx == 288) last_cyc = cyc;
      end
    end
    if (finish) begin
      fin_cnt++;
      chk("finish_delay", cyc - last_cyc, 1);
    end
  end
  task automatic gen(input int kind, input int vi, output logic [71:0] pw, output logic [71:0] gw);
    for (int i = 0; i < 9; i++) begin
      pw[i*8 +: 8] = kind == 0 ? 8'(tab[vi].p) : 8'($urandom);
      gw[i*8 +: 8] = kind == 0 ? 8'(tab[vi].w) : 8'($urandom);
    end
  endtask
  task automatic run_map(input int kind, input int vi, input int ncyc, input bit tog, input bit hold_start);
    int acc = 0, f0 = fin_cnt;
    logic [71:0] pw, gw;
    start = 1;
    @(posedge clk); #1;
    start = hold_start;
    chk("busy_run", int'(busy), 1);
    for (int c = 0; c < ncyc; c++) begin
      gen(kind, vi, pw, gw);
      win = pw;
      wgt = gw;
      in_valid = !tog || c % 2 == 0;
      if (in_valid && acc < 289) begin
        q.push_back('{kind == 0 ? tab[vi].e : model(pw, gw), acc, cyc});
        acc++;
      end
      @(posedge clk); #1;
    end
    in_valid = 0;
    start = 0;
    for (int t = 0; t < 20 && fin_cnt == f0; t++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    chk("finish_count", fin_cnt - f0, 1);
    chk("queue_empty", q.size(), 0);
    chk("busy_idle", int'(busy), 0);
    q.delete();
  endtask
  initial begin
    int f0;
    logic [71:0] pw, gw;
    tab[0] = '{1, 16, 9};
    tab[1] = '{16, 16, 127};
    tab[2] = '{-128, -128, 127};
    tab[3] = '{1, -16, clampv(-9)};
    tab[4] = '{3, 5, 8};
    tab[5] = '{-3, 5, clampv(-9)};
    tab[6] = '{127, -128, clampv(-9144)};
    tab[7] = '{0, 0, 0};
    tab[8] = '{-1, 1, clampv(-1)};
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_finish", int'(finish), 0);
    chk("rst_out_xy", int'({out_x, out_y}), 0);
    #2 xrst = 0;
    for (int v = 0; v < 9; v++) run_map(0, v, 289, 0, 0);
    run_map(1, 0, 289, 0, 0);
    run_map(1, 0, 578, 1, 1);
    // Abandon a map mid-flight with an asynchronous reset
    f0 = fin_cnt;
    start = 1;
    @(posedge clk); #1;
    start = 0;
    for (int c = 0; c < 100; c++) begin
      gen(1, 0, pw, gw);
      win = pw;
      wgt = gw;
      in_valid = 1;
      q.push_back('{model(pw, gw), c, cyc});
      @(posedge clk); #1;
    end
    in_valid = 0;
    #2 xrst = 1;
    #1;
    chk("arst_out_valid", int'(out_valid), 0);
    chk("arst_out_data", int'(out_data), 0);
    chk("arst_out_x", int'(out_x), 0);
    chk("arst_out_y", int'(out_y), 0);
    chk("arst_busy", int'(busy), 0);
    q.delete();
    @(posedge clk); #3;
    xrst = 0;
    repeat (10) @(posedge clk);
    #1;
    chk("arst_no_finish", fin_cnt - f0, 0);
    chk("arst_idle", int'(busy), 0);
    run_map(1, 0, 289, 0, 0);
    run_map(1, 0, 300, 0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
